// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the elastic FIFO and its burst read controller.
// Default geometry must stay in step with the FIFO instance it drains.
package fifo_burst_reader_pkg;

   localparam int FIFO_DEPTH = 32;
   localparam int FIFO_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_burst_reader_stream_skid_buf.sv
// Two-entry in-order valid/ready buffer. The producer is credit-limited by
// its owner, so a push into a full buffer without a pop never happens.
module stream_skid_buf #(
   parameter int width = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [width-1:0] in_data,
   output logic [1:0]       occ,
   output logic             out_valid,
   output logic [width-1:0] out_data,
   input  logic             out_ready
);

   logic [width-1:0] ent0, ent1;
   logic [1:0]       cnt;
   logic             push, pop;

   assign push = in_valid;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= in_data;
               else if (cnt == 2'd1) ent1 <= in_data;
               if (cnt != 2'd2) cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // pop implies cnt >= 1; occupancy is unchanged
               if (cnt == 2'd1) begin
                  ent0 <= in_data;
               end else begin
                  ent0 <= ent1;
                  ent1 <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign occ       = cnt;
   assign out_valid = (cnt != 2'd0);
   assign out_data  = ent0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the synchronous FIFO in fixed-length (or flush-triggered short)
// bursts onto a valid/ready stream with a last-word marker.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int depth      = FIFO_DEPTH,
   parameter int width      = FIFO_WIDTH,
   parameter int log2_depth = $clog2(depth),
   parameter int burst_len  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [width-1:0]    fifo_data,
   input  logic                fifo_empty,
   input  logic [log2_depth:0] fifo_count,
   output logic                fifo_rd_en,
   input  logic                flush,
   output logic [width-1:0]    m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                burst_done,
   output logic                busy
);

   localparam logic [log2_depth:0] BL   = (log2_depth+1)'(burst_len);
   localparam logic [log2_depth:0] ONE  = (log2_depth+1)'(1);
   localparam logic [log2_depth:0] ZERO = '0;

   state_t              state, state_nxt;
   logic [log2_depth:0] remaining, remaining_nxt;
   logic                inflight, inflight_last;
   logic [1:0]          occ;
   logic                head_valid;
   logic [width:0]      head;
   logic                pop, rd_en;
   logic [2:0]          credit;

   assign pop = head_valid && m_ready;

   // Words already buffered plus the one on its way, less the one leaving
   // this cycle, must leave room for the word a new read would bring.
   assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign rd_en  = (state == BURST) && (remaining != ZERO) && !fifo_empty &&
                   (credit < 3'd2);

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      unique case (state)
         IDLE: begin
            if (fifo_count >= BL) begin
               state_nxt     = BURST;
               remaining_nxt = BL;
            end else if (flush && !fifo_empty && (fifo_count != ZERO)) begin
               state_nxt     = BURST;
               remaining_nxt = fifo_count;
            end
         end
         BURST: begin
            if (rd_en) begin
               remaining_nxt = remaining - ONE;
               if (remaining == ONE) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[0]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         remaining     <= ZERO;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nxt;
         remaining     <= remaining_nxt;
         inflight      <= rd_en;
         inflight_last <= rd_en && (remaining == ONE);
      end
   end

   stream_skid_buf #(.width(width + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inflight),
      .in_data   ({fifo_data, inflight_last}),
      .occ       (occ),
      .out_valid (head_valid),
      .out_data  (head),
      .out_ready (m_ready)
   );

   // Outputs are forced quiet for the whole reset window, not just after the edge.
   assign fifo_rd_en = rd_en && !rst;
   assign m_valid    = head_valid && !rst;
   assign m_data     = head[width:1];
   assign m_last     = head[0] && !rst;
   assign burst_done = (state == DRAIN) && pop && head[0] && !rst;
   assign busy       = (state != IDLE) && !rst;

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's synchronous elastic FIFO. It drains the FIFO in fixed-length bursts and presents the words on a valid/ready stream with a last-word marker.
- It drives the FIFO's read enable and tracks the FIFO's one-cycle registered read latency. A 2-entry skid buffer absorbs downstream backpressure without losing or duplicating words.
- It sits between the FIFO and any downstream stream consumer (serializer, packet formatter).

Parameters:
- depth, 32, FIFO depth in words; must match the attached FIFO.
- width, 8, data word width.
- log2_depth, $clog2(depth), FIFO pointer width; the occupancy count is log2_depth+1 bits.
- burst_len, 4, words per normal burst; range 1..depth.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- fifo_data  in  width  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  log2_depth+1  FIFO occupancy.
- fifo_rd_en  out  1  FIFO read enable.
- flush  in  1  level; permits a short burst of whatever the FIFO holds.
- m_data  out  width  output word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word when m_valid && m_ready.
- m_last  out  1  marks the final word of a burst; qualified by m_valid.
- burst_done  out  1  one-cycle pulse when the last word of a burst is accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - Everything is synchronous to the rising edge of clk.
  - rst high: state=IDLE; skid buffer empty; remaining=0; inflight=0.
  - While rst is high, m_valid=0, m_last=0, burst_done=0, busy=0 and fifo_rd_en=0.
  - m_data is 0 after reset.
- Read latency and credit:
  - A read is accepted when fifo_rd_en=1 and fifo_empty=0 at a clock edge; the data is on fifo_data during the next cycle.
  - The inflight register (0/1) marks that fifo_data must be captured into the skid buffer at the next edge.
  - Latency from the rd_en cycle T to the m_valid cycle is 2 (capture at the end of T+1, valid in T+2).
  - pop = m_valid && m_ready.
  - fifo_rd_en = (state==BURST) && (remaining!=0) && !fifo_empty && (occ + inflight - pop < 2). It is combinational from registers plus m_ready and fifo_empty.
  - This guarantees the skid buffer never overflows and allows 1 word/cycle sustained throughput when m_ready=1.
- Skid buffer:
  - 2 entries, FIFO order. Each entry holds {data, last}.
  - Simultaneous capture and pop is permitted; occupancy stays unchanged.
  - m_data and m_last come from the head entry. m_valid = (occ != 0).
  - m_data and m_last hold stable while m_valid && !m_ready.
- FSM:
  - IDLE:
    - If fifo_count >= burst_len: go to BURST with remaining=burst_len.
    - Else if flush && !fifo_empty: go to BURST with remaining=fifo_count (short burst).
    - Normal bursts take priority over flush.
  - BURST:
    - remaining decrements on each accepted read.
    - The word captured from the read that took remaining to 0 gets last=1.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN:
    - No reads are issued.
    - When the last-tagged word pops, pulse burst_done and go to IDLE.
    - Popping the last word and the IDLE evaluation never overlap, so there is a minimum one-cycle gap in fifo_rd_en between bursts.
- Boundaries:
  - In BURST, fifo_empty=1 stalls reads with no error; a burst is never truncated.
  - flush dropping mid-burst has no effect on a burst already started.
  - burst_len=1: every word carries m_last=1.
  - Width: remaining and fifo_count are log2_depth+1 bits, so a count of depth is representable; no wrap-around is possible.
  - Reset mid-burst: buffered and in-flight words are discarded, and the FSM returns to IDLE on the next edge. The FIFO is reset by the same rst.

Decomposition:
- Shared package (team FIFO package):
  - FSM state encoding: IDLE=2'd0, BURST=2'd1, DRAIN=2'd2.
  - Default depth/width constants shared with the FIFO.
- One sub-module, stream_skid_buf: 2-entry valid/ready buffer, parameterised on width+1 bits. The FSM and credit logic stay in the top module.

Test Plan (depth=32, width=8, burst_len=4):
- Reset: hold rst 2 cycles with the FIFO holding 5 words -> fifo_rd_en=0, m_valid=0, busy=0; first rd_en no earlier than 1 cycle after rst falls.
- Threshold: FIFO fills 0x10..0x13 one word per cycle, m_ready=1 -> no rd_en while fifo_count=3. When the count reaches 4: 4 consecutive rd_en cycles; m_data 0x10..0x13 on 4 consecutive cycles, starting 2 cycles after the first rd_en; m_last only on 0x13; burst_done the same cycle as 0x13.
- Backpressure: m_ready=0 from the second output word for 6 cycles -> occ saturates at 2, rd_en low while saturated; on release, words appear in order with none lost or duplicated.
- Flush: FIFO holds 0xA0,0xA1, flush=1 -> burst of 2 words, m_last on 0xA1, burst_done pulses, then IDLE.
- Back-to-back: FIFO holds 8 words, m_ready=1 -> two bursts; m_last on words 4 and 8; at least one idle rd_en cycle between bursts.
- Reset mid-burst: assert rst after 2 words are output -> m_valid=0 next cycle, no further output until new data arrives.
